// File: rtl/npu_pkg.sv
// Shared NPU definitions: MAC FSM state encoding, default widths, clog2 helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package npu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int W_WIDTH_DEF    = 8;
  localparam int ACC_WIDTH_DEF  = 32;

  // Bits needed to index 0..n-1; never less than 1 so a 1-entry port stays legal.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered multiply-accumulate: acc <= acc + sext(zext(pixel) * weight), or acc <= load value.
// Latency: 1 cycle from en/clr to acc update; single-cycle multiplier.
// Backpressure: none; caller strobes en only when pixel/weight are valid.
module mac_unit
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int W_WIDTH    = W_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [ACC_WIDTH-1:0]  i_load_val,
  input  logic [DATA_WIDTH-1:0] i_pixel,
  input  logic [W_WIDTH-1:0]    i_weight,
  output logic [ACC_WIDTH-1:0]  o_acc
);

  // One spare bit so the unsigned pixel stays non-negative as a signed operand.
  localparam int PW = DATA_WIDTH + W_WIDTH + 1;

  logic signed [PW-1:0] w_px;
  logic signed [PW-1:0] w_wt;
  logic signed [PW-1:0] w_prod;
  logic [ACC_WIDTH-1:0] r_acc;

  assign w_px   = PW'($signed({1'b0, i_pixel}));
  assign w_wt   = PW'($signed(i_weight));
  assign w_prod = w_px * w_wt;

  // Accumulator: load wins over accumulate; the sum wraps on overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= i_load_val;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_WIDTH'(w_prod);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/pixel_mac.sv
// Dot product of N_INPUTS fifo pixels with ROM weights plus bias, optional ReLU.
// Latency: N_INPUTS+2 cycles from START to RES_VALID when the fifo never runs empty.
// Backpressure: empty fifo stalls the fetch; result held in DONE until RES_READY.
module pixel_mac
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int W_WIDTH    = W_WIDTH_DEF,
  parameter int N_INPUTS   = 784,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int RELU       = 1
) (
  input  logic                        CLKEXT,
  input  logic                        RST,
  input  logic                        START,
  input  logic [ACC_WIDTH-1:0]        BIAS,
  output logic                        FIFO_RD_EN,
  input  logic [DATA_WIDTH-1:0]       FIFO_DATA,
  input  logic                        FIFO_EMPTY,
  output logic [clog2(N_INPUTS)-1:0]  W_ADDR,
  input  logic [W_WIDTH-1:0]          W_DATA,
  output logic [ACC_WIDTH-1:0]        RES_DATA,
  output logic                        RES_VALID,
  input  logic                        RES_READY,
  output logic                        BUSY
);

  localparam int IW = clog2(N_INPUTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_INPUTS - 1);

  state_t               r_state;
  state_t               w_next;
  logic [IW-1:0]        r_idx;
  logic                 r_pend;
  logic                 w_rd_en;
  logic                 w_load;
  logic [ACC_WIDTH-1:0] w_acc;

  // State register.
  always_ff @(posedge CLKEXT or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, fifo strobe and accumulator load.
  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_load = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!FIFO_EMPTY) begin
          w_rd_en = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        if (RES_READY) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Pixel index advances only on an issued strobe, so an empty fifo holds it.
  always_ff @(posedge CLKEXT or negedge RST) begin
    if (!RST) begin
      r_idx <= '0;
    end else if (w_load) begin
      r_idx <= '0;
    end else if (w_rd_en) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Pending flag: pixel and weight for a strobe arrive one cycle later.
  always_ff @(posedge CLKEXT or negedge RST) begin
    if (!RST) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_rd_en;
    end
  end

  mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .W_WIDTH    (W_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .i_clk      (CLKEXT),
    .i_rst_n    (RST),
    .i_en       (r_pend),
    .i_clr      (w_load),
    .i_load_val (BIAS),
    .i_pixel    (FIFO_DATA),
    .i_weight   (W_DATA),
    .o_acc      (w_acc)
  );

  assign FIFO_RD_EN = w_rd_en;
  assign W_ADDR     = r_idx;
  assign BUSY       = (r_state != S_IDLE);
  assign RES_VALID  = (r_state == S_DONE);
  assign RES_DATA   = (r_state != S_DONE)                   ? '0 :
                      ((RELU != 0) && w_acc[ACC_WIDTH-1])   ? '0 : w_acc;

endmodule

// File: doc/pixel_mac.md
PIXEL_MAC -- requirements
Module: pixel_mac

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 8, unsigned pixel width.
- W_WIDTH, 8, signed weight width.
- N_INPUTS, 784, pixels per dot product.
- ACC_WIDTH, 32, signed accumulator width.
- RELU, 1, clamp negative results to 0 when 1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLKEXT, input, 1, single clock; all logic on its rising edge.
- RST, input, 1, asynchronous active-low reset.
- START, input, 1, one-cycle pulse; begins one dot product.
- BIAS, input, ACC_WIDTH, signed bias, sampled on accepted START.
- FIFO_RD_EN, output, 1, read strobe to upstream fifo.
- FIFO_DATA, input, DATA_WIDTH, fifo DATA_OUT; valid the cycle after the strobe.
- FIFO_EMPTY, input, 1, fifo EMPTY flag.
- W_ADDR, output, clog2(N_INPUTS), weight ROM address.
- W_DATA, input, W_WIDTH, signed ROM data; valid the cycle after W_ADDR is issued.
- RES_DATA, output, ACC_WIDTH, signed result.
- RES_VALID, output, 1, result-valid handshake.
- RES_READY, input, 1, consumer accepts result.
- BUSY, output, 1, high in every state except IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, DRAIN and DONE.
REQ-004 IDLE: START=1 SHALL load ACC<=BIAS, IDX<=0 and go to FETCH; START in any other state SHALL be ignored.
REQ-005 FETCH: when FIFO_EMPTY=0, FIFO_RD_EN SHALL be 1 combinationally with W_ADDR=IDX, and IDX SHALL increment.
REQ-006 FIFO_RD_EN SHALL never be asserted while FIFO_EMPTY=1 or outside FETCH; an empty fifo SHALL stall without advancing IDX.
REQ-007 A pending flag SHALL register each strobe; in the following cycle ACC SHALL add sext(FIFO_DATA zero-extended, times W_DATA signed) to ACC_WIDTH.
REQ-008 The product SHALL be DATA_WIDTH+W_WIDTH+1 bits signed; the accumulation SHALL wrap, not saturate. Defaults cannot overflow: 784*255*128 < 2^31.
REQ-009 When the strobe for IDX=N_INPUTS-1 issues, FETCH SHALL go to DRAIN; DRAIN SHALL add the last product and go to DONE next cycle.
REQ-010 Latency SHALL be N_INPUTS+2 cycles from START to RES_VALID with the fifo never empty.
REQ-011 DONE: RES_VALID=1 and RES_DATA SHALL be ACC, or 0 if RELU=1 and ACC<0; both SHALL be held stable until RES_READY=1.
REQ-012 RES_VALID&RES_READY SHALL return the FSM to IDLE next cycle. START in that same cycle SHALL be ignored.
REQ-013 Pixels and weights SHALL pair strictly in order: pixel k with W_ADDR=k.

Reset
REQ-014 RST=0 SHALL immediately force state IDLE, ACC=0, IDX=0, pending=0.
REQ-015 During reset, FIFO_RD_EN, RES_VALID and BUSY SHALL be 0, and RES_DATA and W_ADDR SHALL be 0.
REQ-016 Reset mid-operation SHALL abandon the partial result; pixels already drained are not recovered, so the fifo is reset by the same system reset.

Structure
REQ-017 A shared package npu_pkg SHALL hold the FSM state encoding, the DATA_WIDTH, W_WIDTH and ACC_WIDTH defaults, and the clog2 helper.
REQ-018 One sub-module, mac_unit, SHALL contain the registered multiply-accumulate: inputs en, clr, load value, pixel and weight; output acc.
REQ-019 The multiplier SHALL be single-cycle, with no further pipelining.

Verification
REQ-020 Run with N_INPUTS=4 and an 8-deep fifo model holding A0,A1,A2,A3, W={1,-1,2,0}, BIAS=5, RES_READY=1. RES_DATA SHALL be 5+160-161+324 = 328, with RES_VALID at cycle 6 after START.
REQ-021 Use W={-1,-1,-1,-1}, pixels FF×4, BIAS=0. With RELU=1, RES_DATA SHALL be 0; with RELU=0, it SHALL be -1020.
REQ-022 Empty the fifo after 2 pixels for 3 cycles, then refill. FIFO_RD_EN SHALL stay 0 while EMPTY=1, and the result SHALL be identical to the no-stall run.
REQ-023 Hold RES_READY=0 for 5 cycles in DONE and pulse START. RES_DATA and RES_VALID SHALL stay stable and START SHALL be ignored; with RES_READY=1, the next cycle SHALL be IDLE.
REQ-024 Assert RST=0 asynchronously mid-FETCH at IDX=2. Outputs SHALL go to 0 and state to IDLE at once; after release, a fresh START SHALL produce a correct result with reset fifo contents.
